inst_fetch: RTL

Instruction fetch stage placed between the PC logic and the instruction ROM / decode stage. It generates word addresses for the synchronous instruction memory (one-cycle read latency: address sampled at a clock edge, instruction valid the following cycle). It tags each returned instruction with its PC and presents it to decode over a valid/ready handshake. A one-entry skid buffer absorbs decode stalls, and a redirect port squashes wrong-path fetches.

---
 rtl/inst_fetch.sv | 85 ++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word addresses to a one-cycle-latency ROM, tags
// returned instructions with their PC and hands them to decode through a skid buffer.
module inst_fetch #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [29:0] out_pc,
    output logic [31:0] fetch_count
);

    logic [29:0] f_pc_reg;
    logic        rsp_valid_reg;
    logic [29:0] rsp_pc_reg;
    logic        sk_valid_reg;
    logic [29:0] sk_pc_reg;
    logic [31:0] sk_inst_reg;
    logic [31:0] fetch_count_reg;

    logic        sel_valid;
    logic [31:0] sel_inst;
    logic [29:0] sel_pc;
    logic        accept;
    logic        issue;

    always_comb begin
        sel_valid = sk_valid_reg ? 1'b1        : rsp_valid_reg;
        sel_inst  = sk_valid_reg ? sk_inst_reg : imem_inst;
        sel_pc    = sk_valid_reg ? sk_pc_reg   : rsp_pc_reg;
    end

    // A redirect masks the presented instruction so wrong-path work is never accepted.
    assign out_valid   = sel_valid & ~redirect_valid;
    assign out_inst    = out_valid ? sel_inst : 32'h0;
    assign out_pc      = out_valid ? sel_pc   : 30'h0;
    assign accept      = out_valid & out_ready;
    assign issue       = out_ready | (~sk_valid_reg & ~rsp_valid_reg);
    assign imem_addr   = rst ? RESET_PC : (redirect_valid ? redirect_pc : f_pc_reg);
    assign fetch_count = fetch_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_pc_reg        <= RESET_PC;
            rsp_valid_reg   <= 1'b0;
            rsp_pc_reg      <= 30'h0;
            sk_valid_reg    <= 1'b0;
            sk_pc_reg       <= 30'h0;
            sk_inst_reg     <= 32'h0;
            fetch_count_reg <= 32'h0;
        end else begin
            if (redirect_valid) begin
                sk_valid_reg  <= 1'b0;
                rsp_valid_reg <= 1'b1;
                rsp_pc_reg    <= redirect_pc;
                f_pc_reg      <= redirect_pc + 30'd1;
            end else begin
                if (issue) begin
                    rsp_valid_reg <= 1'b1;
                    rsp_pc_reg    <= f_pc_reg;
                    f_pc_reg      <= f_pc_reg + 30'd1;
                end else begin
                    rsp_valid_reg <= 1'b0;
                end
                // The ROM output is only valid for one cycle, so a stalled response must be parked.
                if (rsp_valid_reg && !sk_valid_reg && !out_ready) begin
                    sk_valid_reg <= 1'b1;
                    sk_pc_reg    <= rsp_pc_reg;
                    sk_inst_reg  <= imem_inst;
                end else if (sk_valid_reg && out_ready) begin
                    sk_valid_reg <= 1'b0;
                end
            end
            if (accept)
                fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

endmodule
